// File: rtl/pwl_map_array.sv
// NCH-channel piecewise-linear code mapper: unsigned ADC codes to signed samples through a shared,
// double-buffered segment table, 2-stage valid pipeline, output saturation and saturation counter.
module pwl_map_array #(
  parameter int unsigned NCH     = 8,
  parameter int unsigned IN_W    = 6,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SEG_B   = 2,
  parameter int unsigned SLOPE_W = 4,
  parameter int unsigned FRAC_W  = 2
) (
  input  logic                   clk,
  input  logic                   arstb,
  input  logic                   in_vld,
  input  logic [NCH*IN_W-1:0]    x_in,
  output logic                   out_vld,
  output logic [NCH*OUT_W-1:0]   x_out,
  output logic                   sat_flag,
  output logic [15:0]            sat_cnt,
  input  logic                   sat_clr,
  input  logic                   cfg_we,
  input  logic [SEG_B-1:0]       cfg_addr,
  input  logic [OUT_W-1:0]       cfg_offset,
  input  logic [SLOPE_W-1:0]     cfg_slope,
  input  logic                   cfg_commit
);

  localparam int unsigned NSEG   = 1 << SEG_B;
  localparam int unsigned XL_W   = IN_W - SEG_B;
  localparam int unsigned PW     = SLOPE_W + XL_W + 1;
  // Two guard bits cover offset + scaled term without overflow before saturation.
  localparam int unsigned SW     = ((PW > OUT_W) ? PW : OUT_W) + 2;
  localparam int          XlSpan = 2 ** XL_W;
  localparam int          Half   = 2 ** (IN_W - 1);

  localparam logic signed [SW-1:0] YMax = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] YMin = ~YMax;

  logic [OUT_W-1:0]       sh_off_q  [NSEG];
  logic [OUT_W-1:0]       sh_off_d  [NSEG];
  logic [SLOPE_W-1:0]     sh_slp_q  [NSEG];
  logic [SLOPE_W-1:0]     sh_slp_d  [NSEG];
  logic [OUT_W-1:0]       act_off_q [NSEG];
  logic [OUT_W-1:0]       act_off_d [NSEG];
  logic [SLOPE_W-1:0]     act_slp_q [NSEG];
  logic [SLOPE_W-1:0]     act_slp_d [NSEG];

  logic                   s1_vld_q, s1_vld_d;
  logic [XL_W-1:0]        s1_xl_q   [NCH];
  logic [XL_W-1:0]        s1_xl_d   [NCH];
  logic [OUT_W-1:0]       s1_off_q  [NCH];
  logic [OUT_W-1:0]       s1_off_d  [NCH];
  logic [SLOPE_W-1:0]     s1_slp_q  [NCH];
  logic [SLOPE_W-1:0]     s1_slp_d  [NCH];

  logic                   out_vld_q, out_vld_d;
  logic [NCH*OUT_W-1:0]   x_out_q, x_out_d;
  logic                   sat_flag_q, sat_flag_d;
  logic [15:0]            sat_cnt_q, sat_cnt_d;

  // A same-cycle shadow write is folded in before the commit copy.
  always_comb begin
    sh_off_d  = sh_off_q;
    sh_slp_d  = sh_slp_q;
    act_off_d = act_off_q;
    act_slp_d = act_slp_q;
    if (cfg_we) begin
      sh_off_d[cfg_addr] = cfg_offset;
      sh_slp_d[cfg_addr] = cfg_slope;
    end
    if (cfg_commit) begin
      act_off_d = sh_off_d;
      act_slp_d = sh_slp_d;
    end
  end

  always_comb begin
    logic [SEG_B-1:0] seg;
    seg      = '0;
    s1_vld_d = in_vld;
    s1_xl_d  = s1_xl_q;
    s1_off_d = s1_off_q;
    s1_slp_d = s1_slp_q;
    if (in_vld) begin
      for (int c = 0; c < NCH; c++) begin
        seg         = x_in[c*IN_W+XL_W +: SEG_B];
        s1_xl_d[c]  = x_in[c*IN_W +: XL_W];
        s1_off_d[c] = act_off_q[seg];
        s1_slp_d[c] = act_slp_q[seg];
      end
    end
  end

  always_comb begin
    logic signed [SW-1:0] prod;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] acc;
    logic [NCH*OUT_W-1:0] y_pk;
    logic                 any_sat;
    rnd             = '0;
    rnd[FRAC_W-1]   = 1'b1;
    prod            = '0;
    acc             = '0;
    y_pk            = '0;
    any_sat         = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      prod = $signed({{(SW-SLOPE_W){s1_slp_q[c][SLOPE_W-1]}}, s1_slp_q[c]})
           * $signed({{(SW-XL_W){1'b0}}, s1_xl_q[c]});
      acc  = (prod + rnd) >>> FRAC_W;
      acc  = acc + $signed({{(SW-OUT_W){s1_off_q[c][OUT_W-1]}}, s1_off_q[c]});
      if (acc > YMax) begin
        y_pk[c*OUT_W +: OUT_W] = YMax[OUT_W-1:0];
        any_sat                = 1'b1;
      end else if (acc < YMin) begin
        y_pk[c*OUT_W +: OUT_W] = YMin[OUT_W-1:0];
        any_sat                = 1'b1;
      end else begin
        y_pk[c*OUT_W +: OUT_W] = acc[OUT_W-1:0];
      end
    end

    out_vld_d  = s1_vld_q;
    x_out_d    = x_out_q;
    sat_flag_d = sat_flag_q;
    if (s1_vld_q) begin
      x_out_d    = y_pk;
      sat_flag_d = any_sat;
    end

    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (s1_vld_q && any_sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      // Identity table: y = x - 2^(IN_W-1), offset-binary to two's complement.
      for (int s = 0; s < NSEG; s++) begin
        sh_off_q[s]  <= OUT_W'(s * XlSpan - Half);
        act_off_q[s] <= OUT_W'(s * XlSpan - Half);
        sh_slp_q[s]  <= SLOPE_W'(2 ** FRAC_W);
        act_slp_q[s] <= SLOPE_W'(2 ** FRAC_W);
      end
      for (int c = 0; c < NCH; c++) begin
        s1_xl_q[c]  <= '0;
        s1_off_q[c] <= '0;
        s1_slp_q[c] <= '0;
      end
      s1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      x_out_q    <= '0;
      sat_flag_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      sh_off_q   <= sh_off_d;
      sh_slp_q   <= sh_slp_d;
      act_off_q  <= act_off_d;
      act_slp_q  <= act_slp_d;
      s1_vld_q   <= s1_vld_d;
      s1_xl_q    <= s1_xl_d;
      s1_off_q   <= s1_off_d;
      s1_slp_q   <= s1_slp_d;
      out_vld_q  <= out_vld_d;
      x_out_q    <= x_out_d;
      sat_flag_q <= sat_flag_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign x_out    = x_out_q;
  assign sat_flag = sat_flag_q;
  assign sat_cnt  = sat_cnt_q;

endmodule
